// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and result valid/ready bus between a CPU/test sequencer and the ALU sequencer
// Ports: none; signals cmd_valid/cmd_ready/cmd_x/cmd_y/cmd_comp and res_valid/res_ready/res_out/res_zr/res_ng/res_err
interface alu_op_sequencer_if #(parameter int WIDTH = 16) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_x;
  logic [WIDTH-1:0] cmd_y;
  logic [5:0]       cmd_comp;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_out;
  logic             res_zr;
  logic             res_ng;
  logic             res_err;
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_comp, res_ready,
    input  cmd_ready, res_valid, res_out, res_zr, res_ng, res_err
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_comp, res_ready,
    output cmd_ready, res_valid, res_out, res_zr, res_ng, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives Hack ALU inputs from accepted commands, waits a settle interval, returns checked results
// Ports: clk, rst_n (async active-low); seq_if slave (cmd_* in, res_* out);
//   alu_x_o/alu_y_o/alu_ctl_o to the ALU, alu_out_i/alu_zr_i/alu_ng_i from it;
//   op_count_o counts result handshakes (wraps), err_count_o counts flagged results (saturates)
module alu_op_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave seq_if,
  output logic [WIDTH-1:0]  alu_x_o,
  output logic [WIDTH-1:0]  alu_y_o,
  output logic [5:0]        alu_ctl_o,
  input  logic [WIDTH-1:0]  alu_out_i,
  input  logic              alu_zr_i,
  input  logic              alu_ng_i,
  output logic [CNT_W-1:0]  op_count_o,
  output logic [CNT_W-1:0]  err_count_o
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {INIT, IDLE, DRIVE, HOLD} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] alu_x_q, alu_y_q, res_out_q;
  logic [5:0]       alu_ctl_q;
  logic             cmd_ready_q, res_valid_q, res_zr_q, res_ng_q, res_err_q;
  logic [CNT_W-1:0] op_cnt_q, err_cnt_q, op_cnt_d, err_cnt_d;
  logic             err_d;
  // Flags must agree with the data the ALU actually produced
  assign err_d     = (alu_zr_i != (alu_out_i == '0)) | (alu_ng_i != alu_out_i[WIDTH-1]);
  assign op_cnt_d  = op_cnt_q + 1'b1;
  assign err_cnt_d = (res_err_q && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_ctl_q   <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_zr_q    <= 1'b0;
      res_ng_q    <= 1'b0;
      res_err_q   <= 1'b0;
      op_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        IDLE: if (seq_if.cmd_valid) begin
          alu_x_q     <= seq_if.cmd_x;
          alu_y_q     <= seq_if.cmd_y;
          alu_ctl_q   <= seq_if.cmd_comp;
          cnt_q       <= CW'(SETTLE_CYCLES - 1);
          cmd_ready_q <= 1'b0;
          state_q     <= DRIVE;
        end
        DRIVE: if (cnt_q == '0) begin
          res_out_q   <= alu_out_i;
          res_zr_q    <= alu_zr_i;
          res_ng_q    <= alu_ng_i;
          res_err_q   <= err_d;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        HOLD: if (seq_if.res_ready) begin
          res_valid_q <= 1'b0;
          op_cnt_q    <= op_cnt_d;
          err_cnt_q   <= err_cnt_d;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign seq_if.cmd_ready = cmd_ready_q;
  assign seq_if.res_valid = res_valid_q;
  assign seq_if.res_out   = res_out_q;
  assign seq_if.res_zr    = res_zr_q;
  assign seq_if.res_ng    = res_ng_q;
  assign seq_if.res_err   = res_err_q;
  assign alu_x_o          = alu_x_q;
  assign alu_y_o          = alu_y_q;
  assign alu_ctl_o        = alu_ctl_q;
  assign op_count_o       = op_cnt_q;
  assign err_count_o      = err_cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer with a behavioural Hack ALU
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n, fault;
  int n_tests = 0, n_fails = 0;
  function automatic logic [15:0] hack(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    a = c[4] ? ~a : a;
    b = c[3] ? 16'h0 : y;
    b = c[2] ? ~b : b;
    o = c[1] ? a + b : a & b;
    return c[0] ? ~o : o;
  endfunction
  alu_op_sequencer_if #(.WIDTH(16)) cif_a ();
  alu_op_sequencer_if #(.WIDTH(16)) cif_b ();
  logic [15:0] ax_a, ay_a, ao_a, ax_b, ay_b, ao_b, opc_b, errc_b;
  logic [5:0]  ac_a, ac_b;
  logic [3:0]  opc_a, errc_a;
  logic        azr_a, ang_a, azr_b, ang_b;
  assign ao_a  = hack(ax_a, ay_a, ac_a);
  assign azr_a = fault ? 1'b0 : (ao_a == 16'h0);
  assign ang_a = ao_a[15];
  assign ao_b  = hack(ax_b, ay_b, ac_b);
  assign azr_b = (ao_b == 16'h0);
  assign ang_b = ao_b[15];
  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .seq_if(cif_a),
    .alu_x_o(ax_a), .alu_y_o(ay_a), .alu_ctl_o(ac_a),
    .alu_out_i(ao_a), .alu_zr_i(azr_a), .alu_ng_i(ang_a),
    .op_count_o(opc_a), .err_count_o(errc_a)
  );
  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .seq_if(cif_b),
    .alu_x_o(ax_b), .alu_y_o(ay_b), .alu_ctl_o(ac_b),
    .alu_out_i(ao_b), .alu_zr_i(azr_b), .alu_ng_i(ang_b),
    .op_count_o(opc_b), .err_count_o(errc_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    int n = 0;
    while (cif_a.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("cmd_ready_timeout", {31'b0, cif_a.cmd_ready}, 32'd1);
    cif_a.cmd_x     = x;
    cif_a.cmd_y     = y;
    cif_a.cmd_comp  = c;
    cif_a.cmd_valid = 1'b1;
    @(negedge clk);
    cif_a.cmd_valid = 1'b0;
  endtask
  task automatic wait_res;
    int n = 0;
    while (cif_a.res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("res_valid_timeout", {31'b0, cif_a.res_valid}, 32'd1);
  endtask
  task automatic take;
    cif_a.res_ready = 1'b1;
    @(negedge clk);
    cif_a.res_ready = 1'b0;
  endtask
  task automatic reset_a;
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
  endtask
  logic [5:0]  t1_c [4] = '{6'b101010, 6'b000010, 6'b010011, 6'b000111};
  logic [15:0] t1_o [4] = '{16'h0000, 16'h0014, 16'h000E, 16'hFFF2};
  logic [5:0]  t2_c [3] = '{6'b111010, 6'b001101, 6'b110111};
  logic [15:0] t2_o [3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    fault = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    cif_a.cmd_valid = 1'b0; cif_a.res_ready = 1'b0;
    cif_a.cmd_x = '0; cif_a.cmd_y = '0; cif_a.cmd_comp = '0;
    cif_b.cmd_valid = 1'b0; cif_b.res_ready = 1'b0;
    cif_b.cmd_x = '0; cif_b.cmd_y = '0; cif_b.cmd_comp = '0;
    #12;
    chk("rst_cmd_ready", cif_a.cmd_ready, 0);
    chk("rst_res_valid", cif_a.res_valid, 0);
    chk("rst_alu_x", ax_a, 0);
    chk("rst_op_count", opc_a, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1 chk("init_cmd_ready", cif_a.cmd_ready, 0);
    @(negedge clk);
    chk("idle_cmd_ready", cif_a.cmd_ready, 1);
    // basic ops with single-cycle settle latency
    for (int i = 0; i < 4; i++) begin
      issue(16'h0011, 16'h0003, t1_c[i]);
      chk("t1_valid_early", cif_a.res_valid, 0);
      @(negedge clk);
      chk("t1_valid_lat", cif_a.res_valid, 1);
      chk("t1_out", cif_a.res_out, t1_o[i]);
      chk("t1_zr", cif_a.res_zr, (t1_o[i] == 16'h0) ? 1 : 0);
      chk("t1_ng", cif_a.res_ng, t1_o[i][15]);
      chk("t1_err", cif_a.res_err, 0);
      take;
    end
    chk("t1_op_count", opc_a, 4);
    reset_a;
    for (int i = 0; i < 3; i++) begin
      issue(16'h0000, 16'hFFFF, t2_c[i]);
      wait_res;
      chk("t2_out", cif_a.res_out, t2_o[i]);
      chk("t2_zr", cif_a.res_zr, (t2_o[i] == 16'h0) ? 1 : 0);
      chk("t2_ng", cif_a.res_ng, t2_o[i][15]);
      take;
    end
    chk("t2_op_count", opc_a, 3);
    // stall in HOLD with a stray command pulse
    issue(16'h0011, 16'h0003, 6'b000010);
    wait_res;
    for (int i = 0; i < 5; i++) begin
      cif_a.cmd_x = 16'h1234;
      cif_a.cmd_valid = (i == 2);
      @(negedge clk);
      chk("t3_valid", cif_a.res_valid, 1);
      chk("t3_out", cif_a.res_out, 16'h0014);
      chk("t3_cmd_ready", cif_a.cmd_ready, 0);
    end
    cif_a.cmd_valid = 1'b0;
    chk("t3_alu_x_hold", ax_a, 16'h0011);
    take;
    chk("t3_post_valid", cif_a.res_valid, 0);
    chk("t3_post_out", cif_a.res_out, 16'h0014);
    chk("t3_alu_x_idle", ax_a, 16'h0011);
    chk("t3_op_count", opc_a, 4);
    // inconsistent flags from a faulty ALU
    reset_a;
    fault = 1'b1;
    issue(16'h0011, 16'h0003, 6'b101010);
    wait_res;
    chk("t4_out", cif_a.res_out, 0);
    chk("t4_zr", cif_a.res_zr, 0);
    chk("t4_err", cif_a.res_err, 1);
    take;
    chk("t4_err_count", errc_a, 1);
    fault = 1'b0;
    issue(16'h0011, 16'h0003, 6'b000010);
    wait_res;
    chk("t4_err_ok", cif_a.res_err, 0);
    take;
    chk("t4_err_count_kept", errc_a, 1);
    chk("t4_op_count", opc_a, 2);
    // counter wrap and saturation
    reset_a;
    fault = 1'b1;
    repeat (16) begin
      issue(16'h0011, 16'h0003, 6'b101010);
      wait_res;
      take;
    end
    chk("t6_op_wrap", opc_a, 0);
    chk("t6_err_sat16", errc_a, 4'hF);
    issue(16'h0011, 16'h0003, 6'b101010);
    wait_res;
    take;
    chk("t6_op_17", opc_a, 1);
    chk("t6_err_sat17", errc_a, 4'hF);
    fault = 1'b0;
    // three-cycle settle instance: latency, then reset during DRIVE
    chk("t5_ready", cif_b.cmd_ready, 1);
    cif_b.cmd_x = 16'h0011; cif_b.cmd_y = 16'h0003; cif_b.cmd_comp = 6'b000010;
    cif_b.cmd_valid = 1'b1;
    @(negedge clk);
    cif_b.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_valid_early", cif_b.res_valid, 0);
      @(negedge clk);
    end
    chk("t5_valid_lat", cif_b.res_valid, 1);
    chk("t5_out", cif_b.res_out, 16'h0014);
    cif_b.res_ready = 1'b1;
    @(negedge clk);
    cif_b.res_ready = 1'b0;
    chk("t5_op_count", opc_b, 1);
    cif_b.cmd_comp = 6'b010011;
    cif_b.cmd_valid = 1'b1;
    @(negedge clk);
    cif_b.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_alu_x_drive", ax_b, 16'h0011);
    #2 rst_b_n = 1'b0;
    #1;
    chk("t5_rst_cmd_ready", cif_b.cmd_ready, 0);
    chk("t5_rst_alu_x", ax_b, 0);
    chk("t5_rst_alu_y", ay_b, 0);
    chk("t5_rst_alu_ctl", ac_b, 0);
    chk("t5_rst_res_valid", cif_b.res_valid, 0);
    chk("t5_rst_res_out", cif_b.res_out, 0);
    chk("t5_rst_op_count", opc_b, 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    #1 chk("t5_init_ready", cif_b.cmd_ready, 0);
    @(negedge clk);
    chk("t5_idle_ready", cif_b.cmd_ready, 1);
    chk("t5_no_result", cif_b.res_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule
